// File: rtl/mos6502_prefetch_queue.sv
// rtl/mos6502_prefetch_queue.sv - 6502 instruction prefetch FIFO; optional PFQ_PEEK2_EN adds second-entry peek and double pop
module mos6502_prefetch_queue #(
  parameter int                   DATA_W   = 8,
  parameter int                   ADDR_W   = 16,
  parameter int                   DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = 16'hFFFC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rdy,
  output logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_req,
  input  logic [DATA_W-1:0]          mem_din,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          flush_pc,
  output logic                       q_valid,
  output logic [DATA_W-1:0]          q_data,
  output logic [ADDR_W-1:0]          q_pc,
  input  logic                       q_pop,
`ifdef PFQ_PEEK2_EN
  output logic                       q_valid1,
  output logic [DATA_W-1:0]          q_data1,
  output logic [ADDR_W-1:0]          q_pc1,
  input  logic                       q_pop2,
`endif
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [ADDR_W-1:0]   pc_q   [DEPTH];
  logic [PW-1:0]       rptr_q, wptr_q;
  logic [CW-1:0]       count_q;
  logic                inflight_q;
  logic [ADDR_W-1:0]   fetch_addr_q;
  logic [ADDR_W-1:0]   issue_pc_q;
  logic [1:0]          pop_n;
  logic                issue;
  logic                capture;
  logic                req;

  assign fetch_addr = fetch_addr_q;
  assign fetch_req  = req;
  assign q_count    = count_q;
  assign q_valid    = (count_q != '0);
  assign q_data     = data_q[rptr_q];
  assign q_pc       = pc_q[rptr_q];

`ifdef PFQ_PEEK2_EN
  assign q_valid1 = (count_q >= CW'(2));
  assign q_data1  = data_q[rptr_q + PW'(1)];
  assign q_pc1    = pc_q[rptr_q + PW'(1)];
`endif

  // Number of entries consumed this cycle; an empty queue ignores pops
  always_comb begin
    pop_n = 2'd0;
    if (q_pop && q_valid) pop_n = 2'd1;
`ifdef PFQ_PEEK2_EN
    if (q_pop2 && (count_q >= CW'(2))) pop_n = 2'd2;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush always lands in S_ISSUE
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_ISSUE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ISSUE;
        S_ISSUE: if (issue) state_d = S_WAIT;
        S_WAIT:  if (rdy) state_d = issue ? S_WAIT : S_ISSUE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: request when the queue plus the in-flight byte leaves room; in
  // S_WAIT the room check accounts for this cycle's capture and pop
  always_comb begin
    req     = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_ISSUE: req = ((count_q + CW'(inflight_q)) < DEPTH_C);
      S_WAIT: begin
        req     = ((count_q + CW'(1) - CW'(pop_n)) < DEPTH_C);
        capture = rdy && inflight_q;
      end
      default: req = 1'b0;
    endcase
    if (flush) begin
      req     = 1'b0;
      capture = 1'b0;
    end
    issue = req && rdy;
  end

  // Queue storage, pointers, count and fetch address
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      fetch_addr_q <= RESET_PC;
      issue_pc_q   <= '0;
    end else if (flush) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      fetch_addr_q <= flush_pc;
    end else begin
      if (capture) begin
        data_q[wptr_q] <= mem_din;
        pc_q[wptr_q]   <= issue_pc_q;
        wptr_q         <= wptr_q + PW'(1);
      end
      rptr_q  <= rptr_q + PW'(pop_n);
      count_q <= count_q + CW'(capture) - CW'(pop_n);
      if (issue) begin
        issue_pc_q   <= fetch_addr_q;
        fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
        inflight_q   <= 1'b1;
      end else if (capture) begin
        inflight_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mos6502_prefetch_queue.sv
// tb/tb_mos6502_prefetch_queue.sv - directed bench for mos6502_prefetch_queue
module tb_mos6502_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        rdy;
  logic [15:0] fetch_addr;
  logic        fetch_req;
  logic [7:0]  mem_din;
  logic        flush;
  logic [15:0] flush_pc;
  logic        q_valid;
  logic [7:0]  q_data;
  logic [15:0] q_pc;
  logic        q_pop;
  logic [2:0]  q_count;
`ifdef PFQ_PEEK2_EN
  logic        q_valid1;
  logic [7:0]  q_data1;
  logic [15:0] q_pc1;
  logic        q_pop2;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] last_addr = 16'h0000;
  logic [15:0] exp_pc [4];

  mos6502_prefetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .rdy        (rdy),
    .fetch_addr (fetch_addr),
    .fetch_req  (fetch_req),
    .mem_din    (mem_din),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .q_valid    (q_valid),
    .q_data     (q_data),
    .q_pc       (q_pc),
    .q_pop      (q_pop),
`ifdef PFQ_PEEK2_EN
    .q_valid1   (q_valid1),
    .q_data1    (q_data1),
    .q_pc1      (q_pc1),
    .q_pop2     (q_pop2),
`endif
    .q_count    (q_count)
  );

  always #5 clk = ~clk;

  // Memory: returns the low byte of the address issued on the previous accepted request
  always @(posedge clk) begin
    if (reset && fetch_req && rdy) last_addr <= fetch_addr;
  end
  assign mem_din = last_addr[7:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] cnt, input logic [15:0] addr, input logic req);
    check({tag, ".count"}, 32'(q_count), 32'(cnt));
    check({tag, ".addr"}, 32'(fetch_addr), 32'(addr));
    check({tag, ".req"}, 32'(fetch_req), 32'(req));
  endtask

  initial begin
    reset = 1'b0; rdy = 1'b1; flush = 1'b0; flush_pc = 16'h0000; q_pop = 1'b0;
`ifdef PFQ_PEEK2_EN
    q_pop2 = 1'b0;
`endif
    step(); step();
    chk_state("rst", 3'd0, 16'hFFFC, 1'b0);
    check("rst.valid", 32'(q_valid), 0);
    check("rst.data", 32'(q_data), 0);
    check("rst.pc", 32'(q_pc), 0);

    // Release: idle, issue FFFC, capture FC
    reset = 1'b1;
    step();
    chk_state("rel0", 3'd0, 16'hFFFC, 1'b1);
    step();
    chk_state("rel1", 3'd0, 16'hFFFD, 1'b1);
    check("rel1.valid", 32'(q_valid), 0);
    step();
    chk_state("rel2", 3'd1, 16'hFFFE, 1'b1);
    check("rel2.valid", 32'(q_valid), 1);
    check("rel2.data", 32'(q_data), 32'h00FC);
    check("rel2.pc", 32'(q_pc), 32'hFFFC);

    // Fill with no pops: saturates at 4, fetch_addr wraps to 0000
    step(); chk_state("fill3", 3'd2, 16'hFFFF, 1'b1);
    step(); chk_state("fill4", 3'd3, 16'h0000, 1'b0);
    step(); chk_state("full0", 3'd4, 16'h0000, 1'b0);
    step(); chk_state("full1", 3'd4, 16'h0000, 1'b0);
    check("full.head", 32'(q_data), 32'h00FC);

    // One pop re-issues exactly one fetch
    q_pop = 1'b1; #1;
    check("pop.req", 32'(fetch_req), 0);
    step(); q_pop = 1'b0; #1;
    chk_state("pop1", 3'd3, 16'h0000, 1'b1);
    check("pop1.pc", 32'(q_pc), 32'hFFFD);
    step(); chk_state("pop2", 3'd3, 16'h0001, 1'b0);
    step(); chk_state("pop3", 3'd4, 16'h0001, 1'b0);
    step(); chk_state("pop4", 3'd4, 16'h0001, 1'b0);

    // rdy=0 while a read is in flight
    q_pop = 1'b1;
    step(); q_pop = 1'b0;
    step(); chk_state("rdy.iss", 3'd3, 16'h0002, 1'b0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rdy0.count", 32'(q_count), 3);
      check("rdy0.addr", 32'(fetch_addr), 32'h0002);
      check("rdy0.pc", 32'(q_pc), 32'hFFFE);
    end
    rdy = 1'b1;
    step(); chk_state("rdy1", 3'd4, 16'h0002, 1'b0);

    // Flush with 3 held and one in flight
    q_pop = 1'b1;
    step(); q_pop = 1'b0;
    step(); chk_state("pre.fl", 3'd3, 16'h0003, 1'b0);
    flush = 1'b1; flush_pc = 16'h1234; #1;
    check("fl.req", 32'(fetch_req), 0);
    step(); flush = 1'b0; #1;
    chk_state("fl1", 3'd0, 16'h1234, 1'b1);
    check("fl1.valid", 32'(q_valid), 0);
    step();
    check("fl2.valid", 32'(q_valid), 0);
    check("fl2.count", 32'(q_count), 0);
    step();
    check("fl3.valid", 32'(q_valid), 1);
    check("fl3.count", 32'(q_count), 1);
    check("fl3.data", 32'(q_data), 32'h0034);
    check("fl3.pc", 32'(q_pc), 32'h1234);

    // Flush to FFFE and pop every cycle across the wrap
    flush = 1'b1; flush_pc = 16'hFFFE;
    step(); flush = 1'b0;
    step(); step();
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    q_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("wrap.valid", 32'(q_valid), 1);
      check("wrap.pc", 32'(q_pc), 32'(exp_pc[i]));
      check("wrap.data", 32'(q_data), 32'(exp_pc[i][7:0]));
      step();
    end
    q_pop = 1'b0;
    check("wrap.count", 32'(q_count), 1);
    check("wrap.head", 32'(q_pc), 32'h0002);

    // Pop and capture together at count 2
    step();
    check("pc2.count", 32'(q_count), 2);
    q_pop = 1'b1;
    step(); q_pop = 1'b0; #1;
    check("pc2.same", 32'(q_count), 2);
    check("pc2.head", 32'(q_pc), 32'h0003);
`ifdef PFQ_PEEK2_EN
    check("pk.valid1", 32'(q_valid1), 1);
    check("pk.pc1", 32'(q_pc1), 32'h0004);
    check("pk.data1", 32'(q_data1), 32'h0004);
    q_pop2 = 1'b1; q_pop = 1'b1;
    step(); q_pop2 = 1'b0; q_pop = 1'b0; #1;
    check("pk.count", 32'(q_count), 1);
    check("pk.head", 32'(q_pc), 32'h0005);
`endif

    // Reset mid-operation
    reset = 1'b0;
    step();
    chk_state("mrst", 3'd0, 16'hFFFC, 1'b0);
    check("mrst.valid", 32'(q_valid), 0);
    check("mrst.pc", 32'(q_pc), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
